// File: rtl/speed_loop_pkg.sv
// Shared types and constants for the speed-loop sequencer and its PWM stage.
package speed_loop_pkg;

   typedef enum logic [1:0] {IDLE, MEASURE, LATCH} sls_state_t;

   localparam int SPEED_W           = 8;
   localparam int DUTY_W            = 8;
   localparam int WINDOW_CYCLES_DEF = 5_000_000;
   localparam int PWM_DIV_DEF       = 8;

endpackage

// File: rtl/speed_loop_sequencer_pwm_gen.sv
// Prescaled 8-bit PWM with duty captured only at period wrap, so the output never glitches.
module pwm_gen
   import speed_loop_pkg::*;
#(
   parameter int PWM_DIV = PWM_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm_out
);

   localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   logic [PW-1:0]     presc;
   logic [DUTY_W-1:0] pwm_cnt;
   logic [DUTY_W-1:0] duty_q;
   logic              tick;

   assign tick = (presc == PW'(PWM_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc   <= '0;
         pwm_cnt <= '0;
         duty_q  <= '0;
         pwm_out <= 1'b0;
      end else if (!en) begin
         presc   <= '0;
         pwm_cnt <= '0;
         duty_q  <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= (pwm_cnt < duty_q);
         if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
            // new duty takes effect exactly as pwm_cnt wraps back to 0
            if (pwm_cnt == '1)
               duty_q <= duty;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

endmodule

// File: rtl/speed_loop_sequencer.sv
// Tach-window speed measurement, controller evaluation strobe and PWM drive.
module speed_loop_sequencer
   import speed_loop_pkg::*;
#(
   parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
   parameter int PWM_DIV       = PWM_DIV_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               tach,
   input  logic [DUTY_W-1:0]  duty,
   output logic [SPEED_W-1:0] C,
   output logic               go,
   output logic               pwm_out,
   output logic               busy
);

   localparam int            WW     = $clog2(WINDOW_CYCLES);
   localparam logic [WW-1:0] WLOAD  = WW'(WINDOW_CYCLES - 1);
   localparam logic [WW-1:0] WSTART = WW'(WINDOW_CYCLES - 2);

   sls_state_t         state, state_nx;
   logic [WW-1:0]      wcnt, wcnt_nx;
   logic [SPEED_W-1:0] ecnt, ecnt_nx, ecnt_inc, c_nx;
   logic               s1, s2, s3, tach_rise, go_nx;

   assign tach_rise = s2 & ~s3;
   assign ecnt_inc  = (tach_rise && ecnt != 8'hFF) ? ecnt + SPEED_W'(1) : ecnt;
   assign busy      = (state == MEASURE) || (state == LATCH);

   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      ecnt_nx  = ecnt;
      c_nx     = C;
      go_nx    = 1'b0;
      case (state)
         IDLE: begin
            wcnt_nx = WLOAD;
            ecnt_nx = '0;
            // the enabling cycle already counts as the first window cycle
            if (en) begin
               state_nx = MEASURE;
               wcnt_nx  = WSTART;
            end
         end
         MEASURE: begin
            ecnt_nx = ecnt_inc;
            if (wcnt == '0)
               state_nx = LATCH;
            else
               wcnt_nx = wcnt - WW'(1);
         end
         LATCH: begin
            c_nx     = ecnt_inc;
            go_nx    = en;
            ecnt_nx  = '0;
            wcnt_nx  = WLOAD;
            state_nx = MEASURE;
         end
         default: state_nx = IDLE;
      endcase
      if (!en) begin
         state_nx = IDLE;
         wcnt_nx  = WLOAD;
         ecnt_nx  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         wcnt  <= '0;
         ecnt  <= '0;
         C     <= '0;
         go    <= 1'b0;
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= 1'b0;
      end else begin
         state <= state_nx;
         wcnt  <= wcnt_nx;
         ecnt  <= ecnt_nx;
         C     <= c_nx;
         go    <= go_nx;
         s1    <= tach;
         s2    <= s1;
         s3    <= s2;
      end
   end

   pwm_gen #(.PWM_DIV(PWM_DIV)) u_pwm (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .duty    (duty),
      .pwm_out (pwm_out)
   );

endmodule

// File: tb/tb_speed_loop_sequencer.sv
// Directed bench: window table plus hand sequences for boundaries, PWM, enable drop and reset.
module tb_speed_loop_sequencer;

   localparam int MAXN = 1100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, tach = 1'b0;
   logic [7:0] duty = 8'd0;
   logic [7:0] C;
   logic       go, pwm_out, busy;

   logic       en_b = 1'b0, tach_b = 1'b0;
   logic [7:0] duty_b = 8'd0;
   logic [7:0] cb;
   logic       go_b, pwm_b, busy_b;

   always #5 clk = ~clk;

   speed_loop_sequencer #(.WINDOW_CYCLES(100), .PWM_DIV(1)) dut (
      .clk(clk), .rst(rst), .en(en), .tach(tach), .duty(duty),
      .C(C), .go(go), .pwm_out(pwm_out), .busy(busy));

   speed_loop_sequencer #(.WINDOW_CYCLES(1000), .PWM_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .tach(tach_b), .duty(duty_b),
      .C(cb), .go(go_b), .pwm_out(pwm_b), .busy(busy_b));

   int n_cmp = 0;
   int n_bad = 0;

   bit       tplan [0:MAXN];
   bit       eplan [0:MAXN];
   bit [7:0] dplan [0:MAXN];
   bit       go_log [0:MAXN];
   bit       pwm_log [0:MAXN];
   bit       busy_log [0:MAXN];
   int       c_log [0:MAXN];

   typedef struct {
      int npulse;
      int exp_c;
   } win_vec_t;

   win_vec_t tbl [5];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_plans();
      for (int n = 0; n <= MAXN; n++) begin
         tplan[n] = 1'b0; eplan[n] = 1'b1; dplan[n] = 8'd0;
         go_log[n] = 1'b0; pwm_log[n] = 1'b0; busy_log[n] = 1'b0; c_log[n] = 0;
      end
   endtask

   // step 0 drives the plan right after a clock edge; step n is sampled 1 ns after the n-th edge
   task automatic run(input int ncyc);
      @(posedge clk); #1;
      en = eplan[0]; tach = tplan[0]; duty = dplan[0];
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge clk); #1;
         go_log[n] = go; pwm_log[n] = pwm_out; busy_log[n] = busy; c_log[n] = int'(C);
         en = eplan[n]; tach = tplan[n]; duty = dplan[n];
      end
   endtask

   task automatic idle();
      en = 1'b0; tach = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic int count_go(input int lo, input int hi);
      int c = 0;
      for (int n = lo; n <= hi; n++) c += int'(go_log[n]);
      return c;
   endfunction

   function automatic int count_pwm(input int lo, input int hi);
      int c = 0;
      for (int n = lo; n <= hi; n++) c += int'(pwm_log[n]);
      return c;
   endfunction

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_C", int'(C), 0);
      chk("reset_go", int'(go), 0);
      chk("reset_pwm", int'(pwm_out), 0);
      chk("reset_busy", int'(busy), 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // window table: pulses spaced 2 cycles from the start of each window
      tbl[0] = '{37, 37};
      tbl[1] = '{0, 0};
      tbl[2] = '{1, 1};
      tbl[3] = '{40, 40};
      tbl[4] = '{12, 12};
      clear_plans();
      for (int k = 0; k < 5; k++)
         for (int i = 0; i < tbl[k].npulse; i++)
            tplan[101*k + 1 + 2*i] = 1'b1;
      run(560);
      chk("tbl_C_before_first_latch", c_log[100], 0);
      chk("tbl_go_total", count_go(1, 560), 5);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("tbl_C_w%0d", k), c_log[101*(k+1)], tbl[k].exp_c);
         chk($sformatf("tbl_C_hold_w%0d", k), c_log[101*(k+1) + 50], tbl[k].exp_c);
         chk($sformatf("tbl_go_w%0d", k), int'(go_log[101*(k+1)]), 1);
         chk($sformatf("tbl_go_pre_w%0d", k), int'(go_log[101*(k+1) - 1]), 0);
      end
      idle();

      // window boundary: edge detected in the LATCH cycle vs. pin edge during LATCH
      clear_plans();
      for (int i = 0; i < 10; i++) tplan[1 + 2*i] = 1'b1;
      tplan[98]  = 1'b1;   // rise reaches s2&~s3 in the LATCH cycle
      tplan[100] = 1'b1;   // pin rises during LATCH, lands in window 2
      for (int i = 0; i < 5; i++) tplan[150 + 2*i] = 1'b1;
      run(210);
      chk("bnd_C_w1", c_log[101], 11);
      chk("bnd_C_w2", c_log[202], 6);
      chk("bnd_total", c_log[101] + c_log[202], 17);
      idle();

      // PWM: 64, mid-period change to 192 at pwm_cnt=100, then 0
      clear_plans();
      for (int n = 0; n <= MAXN; n++)
         dplan[n] = (n < 356) ? 8'd64 : (n < 600) ? 8'd192 : 8'd0;
      run(1030);
      chk("pwm_p0_high", count_pwm(1, 256), 0);
      chk("pwm_p1_high", count_pwm(257, 512), 64);
      chk("pwm_p2_high", count_pwm(513, 768), 192);
      chk("pwm_p3_high", count_pwm(769, 1024), 0);
      chk("pwm_first_hi", int'(pwm_log[257]), 1);
      chk("pwm_last_hi", int'(pwm_log[320]), 1);
      chk("pwm_first_lo", int'(pwm_log[321]), 0);
      idle();

      // en dropped in MEASURE of window 3
      clear_plans();
      for (int n = 0; n <= MAXN; n++) begin
         dplan[n] = 8'd255;
         eplan[n] = (n < 280);
      end
      for (int i = 0; i < 4; i++) tplan[1 + 2*i] = 1'b1;
      for (int i = 0; i < 3; i++) tplan[110 + 2*i] = 1'b1;
      for (int i = 0; i < 6; i++) tplan[210 + 2*i] = 1'b1;
      run(400);
      chk("dropm_C_w1", c_log[101], 4);
      chk("dropm_C_w2", c_log[202], 3);
      chk("dropm_C_kept", c_log[400], 3);
      chk("dropm_go_count", count_go(1, 400), 2);
      chk("dropm_pwm_before", int'(pwm_log[280]), 1);
      chk("dropm_pwm_after", int'(pwm_log[281]), 0);
      chk("dropm_busy_before", int'(busy_log[280]), 1);
      chk("dropm_busy_after", int'(busy_log[281]), 0);
      idle();

      // en dropped during the LATCH cycle of window 3
      for (int n = 0; n <= MAXN; n++) eplan[n] = (n < 302);
      run(400);
      chk("dropl_C_latched", c_log[303], 6);
      chk("dropl_C_kept", c_log[400], 6);
      chk("dropl_go_suppressed", int'(go_log[303]), 0);
      chk("dropl_go_count", count_go(1, 400), 2);
      chk("dropl_pwm_before", int'(pwm_log[302]), 1);
      chk("dropl_pwm_after", int'(pwm_log[303]), 0);
      chk("dropl_busy_after", int'(busy_log[303]), 0);
      idle();

      // reset mid-window with edges already counted and C nonzero
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         tach = (i % 2 == 0);
      end
      chk("rstmid_busy_before", int'(busy), 1);
      #3 rst = 1'b1;
      #1;
      chk("rstmid_C", int'(C), 0);
      chk("rstmid_go", int'(go), 0);
      chk("rstmid_pwm", int'(pwm_out), 0);
      chk("rstmid_busy", int'(busy), 0);
      en = 1'b0; tach = 1'b0;
      #20 rst = 1'b0;
      clear_plans();
      for (int i = 0; i < 7; i++) tplan[1 + 2*i] = 1'b1;
      run(110);
      chk("rstmid_C_hold0", c_log[100], 0);
      chk("rstmid_C_after", c_log[101], 7);
      idle();

      // saturation on the long-window instance
      @(posedge clk); #1;
      en_b = 1'b1;
      for (int n = 1; n <= 2010; n++) begin
         @(posedge clk); #1;
         if (n == 1001) chk("sat_C", int'(cb), 255);
         if (n == 1500) chk("sat_C_hold", int'(cb), 255);
         if (n == 2002) chk("post_sat_C", int'(cb), 10);
         tach_b = (((n >= 1) && (n <= 599)) || ((n >= 1011) && (n <= 1029))) && (n % 2 == 1);
      end
      en_b = 1'b0;
      tach_b = 1'b0;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
